// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multi-cycle processor control path.
// Holds the sequencer state enum, opcode/sub-op constants and small decode helpers.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        EXEC,
        MEM,
        WB,
        HALT
    } seq_state_t;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_MEM   = 3'b001;
    localparam logic [2:0] OP_BEQ   = 3'b110;
    localparam logic [2:0] OP_MISC  = 3'b111;

    localparam logic [1:0] SUB_JR   = 2'b11;
    localparam logic [1:0] SUB_HALT = 2'b11;

    // Opcode 001 with sub 10/11 has no defined meaning and runs as a NOP.
    function automatic logic is_illegal(input logic [8:0] instr);
        return (instr[8:6] == OP_MEM) && instr[1];
    endfunction

    function automatic logic is_halt_op(input logic [8:0] instr);
        return (instr[8:6] == OP_MISC) && (instr[1:0] == SUB_HALT);
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Bundle of the signals between the sequencer and instruction memory, decoder,
// register file / ALU and data memory. The sequencer side is the master.
interface cpu_sequencer_if #(
    parameter int INSTR_WIDTH = 9,
    parameter int REG_WIDTH   = 8,
    parameter int PC_WIDTH    = 10
);
    logic                   start;
    logic [INSTR_WIDTH-1:0] instr_in;
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] ir;
    logic                   dec_reg_write;
    logic                   dec_car_write;
    logic                   dec_mem_read;
    logic                   dec_mem_write;
    logic                   dec_halt;
    logic                   alu_zero;
    logic [REG_WIDTH-1:0]   target_val;
    logic                   dmem_req;
    logic                   dmem_ack;
    logic                   mdr_we;
    logic                   reg_we;
    logic                   car_we;
    logic                   dmem_we;
    logic                   busy;
    logic                   halted;

    modport master (
        input  start, instr_in, dec_reg_write, dec_car_write, dec_mem_read,
               dec_mem_write, dec_halt, alu_zero, target_val, dmem_ack,
        output pc, ir, dmem_req, mdr_we, reg_we, car_we, dmem_we, busy, halted
    );

    modport slave (
        output start, instr_in, dec_reg_write, dec_car_write, dec_mem_read,
               dec_mem_write, dec_halt, alu_zero, target_val, dmem_ack,
        input  pc, ir, dmem_req, mdr_we, reg_we, car_we, dmem_we, busy, halted
    );

endinterface

// File: rtl/pc_unit.sv
// Program counter register with next-PC selection: increment, relative branch
// (sign-extended offset) or absolute jump (zero-extended target), plus clear.
module pc_unit #(
    parameter int PC_WIDTH  = 10,
    parameter int REG_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clear,
    input  logic                 i_update,
    input  logic                 i_branch,
    input  logic                 i_jump,
    input  logic [REG_WIDTH-1:0] i_target,
    output logic [PC_WIDTH-1:0]  o_pc
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_offset;
    logic [PC_WIDTH-1:0] w_absolute;
    logic [PC_WIDTH-1:0] w_nextPc;

    assign w_offset   = {{(PC_WIDTH-REG_WIDTH){i_target[REG_WIDTH-1]}}, i_target};
    assign w_absolute = {{(PC_WIDTH-REG_WIDTH){1'b0}}, i_target};

    // Arithmetic is left to wrap naturally at the PC width.
    always_comb begin
        w_nextPc = r_pc + PC_ONE;
        if (i_jump) begin
            w_nextPc = w_absolute;
        end else if (i_branch) begin
            w_nextPc = r_pc + w_offset;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
        end else if (i_clear) begin
            r_pc <= '0;
        end else if (i_update) begin
            r_pc <= w_nextPc;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through fetch, load,
// execute, memory and write-back, and runs the data-memory req/ack handshake.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int INSTR_WIDTH = 9,
    parameter int REG_WIDTH   = 8,
    parameter int PC_WIDTH    = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    cpu_sequencer_if.master bus
);

    seq_state_t             r_state;
    logic [INSTR_WIDTH-1:0] r_ir;
    logic                   r_dmemReq;
    logic                   r_dmemWe;
    logic                   r_regWe;
    logic                   r_carWe;
    logic                   r_busy;
    logic                   r_halted;

    logic [2:0]             w_opcode;
    logic [1:0]             w_sub;
    logic                   w_legal;
    logic                   w_memOp;
    logic                   w_regWrite;
    logic                   w_carWrite;
    logic                   w_startAccept;
    logic                   w_branch;
    logic                   w_jump;
    logic [PC_WIDTH-1:0]    w_pc;

    assign w_opcode = r_ir[INSTR_WIDTH-1 -: 3];
    assign w_sub    = r_ir[1:0];

    // Illegal encodings are masked here so a naive decoder cannot start a memory access.
    assign w_legal    = ~is_illegal(r_ir);
    assign w_memOp    = w_legal & (bus.dec_mem_read | bus.dec_mem_write);
    assign w_regWrite = w_legal & bus.dec_reg_write & ~bus.dec_mem_write;
    assign w_carWrite = w_legal & bus.dec_car_write;

    assign w_startAccept = ((r_state == IDLE) || (r_state == HALT)) && bus.start;
    assign w_branch      = (w_opcode == OP_BEQ) && bus.alu_zero;
    assign w_jump        = (w_opcode == OP_RTYPE) && (w_sub == SUB_JR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ir      <= '0;
            r_dmemReq <= 1'b0;
            r_dmemWe  <= 1'b0;
            r_regWe   <= 1'b0;
            r_carWe   <= 1'b0;
            r_busy    <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_regWe <= 1'b0;
            r_carWe <= 1'b0;
            case (r_state)
                IDLE, HALT: begin
                    if (bus.start) begin
                        r_state  <= FETCH;
                        r_busy   <= 1'b1;
                        r_halted <= 1'b0;
                    end
                end
                FETCH: r_state <= LOAD;
                LOAD: begin
                    r_ir    <= bus.instr_in;
                    r_state <= EXEC;
                end
                EXEC: begin
                    if (bus.dec_halt) begin
                        r_state  <= HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else if (w_memOp) begin
                        r_state   <= MEM;
                        r_dmemReq <= 1'b1;
                        r_dmemWe  <= bus.dec_mem_write;
                    end else begin
                        r_state <= WB;
                        r_regWe <= w_regWrite;
                        r_carWe <= w_carWrite;
                    end
                end
                // Strobes are loaded on the way into WB so they are high for exactly that cycle.
                MEM: begin
                    if (bus.dmem_ack) begin
                        r_state   <= WB;
                        r_dmemReq <= 1'b0;
                        r_dmemWe  <= 1'b0;
                        r_regWe   <= w_regWrite;
                        r_carWe   <= w_carWrite;
                    end
                end
                WB:      r_state <= FETCH;
                default: r_state <= IDLE;
            endcase
        end
    end

    pc_unit #(
        .PC_WIDTH  (PC_WIDTH),
        .REG_WIDTH (REG_WIDTH)
    ) u_pcUnit (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_startAccept),
        .i_update (r_state == WB),
        .i_branch (w_branch),
        .i_jump   (w_jump),
        .i_target (bus.target_val),
        .o_pc     (w_pc)
    );

    assign bus.pc       = w_pc;
    assign bus.ir       = r_ir;
    assign bus.dmem_req = r_dmemReq;
    assign bus.dmem_we  = r_dmemWe;
    assign bus.reg_we   = r_regWe;
    assign bus.car_we   = r_carWe;
    assign bus.busy     = r_busy;
    assign bus.halted   = r_halted;
    assign bus.mdr_we   = (r_state == MEM) && bus.dmem_ack && bus.dec_mem_read;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: bench-side ROM, decoder and data-memory
// responder; per-instruction expectations are queued and compared on completion.
module tb_cpu_sequencer;

    typedef struct {
        logic [9:0] nextPc;
        int         cycles;
        int         regWe;
        int         regWeCycle;
        int         carWe;
        int         carWeCycle;
        int         reqCycles;
        int         weCycles;
        int         mdrCount;
        int         mdrCycle;
        logic [8:0] ir;
        bit         halt;
    } exp_t;

    logic       clk;
    logic       rst_n;
    int         total;
    int         bad;
    logic [8:0] rom [0:1023];
    logic [9:0] modelPc;
    exp_t       sbq[$];

    cpu_sequencer_if bus ();

    cpu_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.instr_in <= rom[bus.pc];

    // Naive decoder: treats every 001 opcode as a memory op and lets SW request a register write.
    always_comb begin
        bus.dec_reg_write = 1'b0;
        bus.dec_car_write = 1'b0;
        bus.dec_mem_read  = 1'b0;
        bus.dec_mem_write = 1'b0;
        bus.dec_halt      = 1'b0;
        case (bus.ir[8:6])
            3'b000: begin
                if (bus.ir[1:0] != 2'b11) begin
                    bus.dec_reg_write = 1'b1;
                    bus.dec_car_write = 1'b1;
                end
            end
            3'b001: begin
                bus.dec_reg_write = 1'b1;
                bus.dec_mem_write = bus.ir[0];
                bus.dec_mem_read  = ~bus.ir[0];
            end
            3'b110: bus.dec_halt = 1'b0;
            3'b111: bus.dec_halt = (bus.ir[1:0] == 2'b11);
            default: begin
                bus.dec_reg_write = 1'b1;
                bus.dec_car_write = 1'b1;
            end
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic exp_t buildExp(input logic [8:0] instr, input logic az, input logic [7:0] tv,
                                      input int ackDelay, input logic [9:0] pcNow);
        exp_t       e;
        logic [2:0] op      = instr[8:6];
        logic [1:0] sb      = instr[1:0];
        bit         isJr    = (op == 3'b000) && (sb == 2'b11);
        bit         isMem   = (op == 3'b001) && !sb[1];
        bit         isLoad  = isMem && !sb[0];
        bit         isStore = isMem && sb[0];
        bit         isAlu   = ((op >= 3'b010) && (op <= 3'b101)) || ((op == 3'b000) && !isJr);
        e.halt       = (op == 3'b111) && (sb == 2'b11);
        e.ir         = instr;
        e.cycles     = e.halt ? 3 : (isMem ? 4 + ackDelay : 4);
        e.regWe      = (isAlu || isLoad) ? 1 : 0;
        e.carWe      = isAlu ? 1 : 0;
        e.regWeCycle = (e.regWe != 0) ? e.cycles : 0;
        e.carWeCycle = (e.carWe != 0) ? e.cycles : 0;
        e.reqCycles  = isMem ? ackDelay : 0;
        e.weCycles   = isStore ? ackDelay : 0;
        e.mdrCount   = isLoad ? 1 : 0;
        e.mdrCycle   = isLoad ? 3 + ackDelay : 0;
        if (e.halt)                      e.nextPc = pcNow;
        else if ((op == 3'b110) && az)   e.nextPc = pcNow + {{2{tv[7]}}, tv};
        else if (isJr)                   e.nextPc = {2'b00, tv};
        else                             e.nextPc = pcNow + 10'd1;
        return e;
    endfunction

    // Entered at the falling edge inside the FETCH cycle; returns at the next FETCH (or HALT).
    task automatic applyStimulus(input string name, input logic [8:0] instr, input logic az,
                                 input logic [7:0] tv, input int ackDelay, input bit noise);
        exp_t       e;
        exp_t       got;
        int         reqSeen;
        bit         done;
        logic [9:0] startPc;
        e = buildExp(instr, az, tv, ackDelay, modelPc);
        sbq.push_back(e);
        rom[modelPc]   = instr;
        bus.alu_zero   = az;
        bus.target_val = tv;
        startPc        = modelPc;
        got            = '{default: 0};
        reqSeen        = 0;
        done           = 1'b0;
        for (int n = 1; n <= 40 && !done; n++) begin
            if (n > 1) @(negedge clk);
            if (n > 1 && (bus.pc != startPc || !bus.busy)) begin
                done       = 1'b1;
                got.cycles = n - 1;
                got.nextPc = bus.pc;
                got.halt   = bus.halted;
                got.ir     = bus.ir;
            end else begin
                if (bus.reg_we) begin got.regWe++; got.regWeCycle = n; end
                if (bus.car_we) begin got.carWe++; got.carWeCycle = n; end
                if (bus.dmem_req) begin got.reqCycles++; reqSeen++; end
                if (bus.dmem_req && bus.dmem_we) got.weCycles++;
                bus.dmem_ack = (bus.dmem_req && reqSeen == ackDelay) || (noise && (n == 2 || n == 3));
                bus.start    = noise && (n == 2 || n == 3);
                #1;
                if (bus.mdr_we) begin got.mdrCount++; got.mdrCycle = n; end
            end
        end
        bus.dmem_ack = 1'b0;
        bus.start    = 1'b0;
        checkOutput({name, ".done"}, 32'(done), 32'd1);
        e = sbq.pop_front();
        checkOutput({name, ".cycles"},     got.cycles,     e.cycles);
        checkOutput({name, ".nextPc"},     32'(got.nextPc), 32'(e.nextPc));
        checkOutput({name, ".ir"},         32'(got.ir),    32'(e.ir));
        checkOutput({name, ".halted"},     32'(got.halt),  32'(e.halt));
        checkOutput({name, ".regWe"},      got.regWe,      e.regWe);
        checkOutput({name, ".regWeCycle"}, got.regWeCycle, e.regWeCycle);
        checkOutput({name, ".carWe"},      got.carWe,      e.carWe);
        checkOutput({name, ".carWeCycle"}, got.carWeCycle, e.carWeCycle);
        checkOutput({name, ".reqCycles"},  got.reqCycles,  e.reqCycles);
        checkOutput({name, ".weCycles"},   got.weCycles,   e.weCycles);
        checkOutput({name, ".mdrCount"},   got.mdrCount,   e.mdrCount);
        checkOutput({name, ".mdrCycle"},   got.mdrCycle,   e.mdrCycle);
        modelPc = e.nextPc;
    endtask

    task automatic pulseStart();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        modelPc   = 10'd0;
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, ".pc"},       32'(bus.pc),       32'd0);
        checkOutput({name, ".ir"},       32'(bus.ir),       32'd0);
        checkOutput({name, ".dmem_req"}, 32'(bus.dmem_req), 32'd0);
        checkOutput({name, ".dmem_we"},  32'(bus.dmem_we),  32'd0);
        checkOutput({name, ".mdr_we"},   32'(bus.mdr_we),   32'd0);
        checkOutput({name, ".reg_we"},   32'(bus.reg_we),   32'd0);
        checkOutput({name, ".car_we"},   32'(bus.car_we),   32'd0);
        checkOutput({name, ".busy"},     32'(bus.busy),     32'd0);
        checkOutput({name, ".halted"},   32'(bus.halted),   32'd0);
    endtask

    // A load whose ack never comes; reset is pulled while the request is pending.
    task automatic resetDuringMem();
        rom[0]       = 9'b001_000_000;
        bus.dmem_ack = 1'b0;
        for (int i = 0; i < 10 && !bus.dmem_req; i++) @(negedge clk);
        checkOutput("rstMem.reqSeen", 32'(bus.dmem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("rstMem");
        bus.dmem_ack = 1'b1;
        #1;
        checkOutput("rstMem.mdrAfterReset", 32'(bus.mdr_we), 32'd0);
        bus.dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rstMem.idleRegWe", 32'(bus.reg_we), 32'd0);
        checkOutput("rstMem.idleBusy",  32'(bus.busy),   32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total          = 0;
        bad            = 0;
        modelPc        = 10'd0;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.dmem_ack   = 1'b0;
        bus.alu_zero   = 1'b0;
        bus.target_val = 8'h00;
        for (int i = 0; i < 1024; i++) rom[i] = 9'b111_000_000;
        #12;
        checkResetOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idleNoStart.busy", 32'(bus.busy), 32'd0);

        pulseStart();
        applyStimulus("add",      9'b010_01_10_00, 1'b0, 8'h00, 0, 1'b0);
        applyStimulus("lw",       9'b001_000_000,  1'b0, 8'h00, 3, 1'b0);
        applyStimulus("sw",       9'b001_000_001,  1'b0, 8'h00, 1, 1'b0);
        applyStimulus("jr5",      9'b000_000_011,  1'b0, 8'h05, 0, 1'b0);
        applyStimulus("beqTaken", 9'b110_000_000,  1'b1, 8'hFE, 0, 1'b0);
        applyStimulus("jr5b",     9'b000_000_011,  1'b0, 8'h05, 0, 1'b0);
        applyStimulus("beqNot",   9'b110_000_000,  1'b0, 8'hFE, 0, 1'b0);
        applyStimulus("ill10",    9'b001_000_010,  1'b0, 8'h00, 0, 1'b0);
        applyStimulus("ill11",    9'b001_000_011,  1'b0, 8'h00, 0, 1'b1);
        applyStimulus("beqBack",  9'b110_000_000,  1'b1, 8'h80, 0, 1'b0);
        applyStimulus("beqUp",    9'b110_000_000,  1'b1, 8'h77, 0, 1'b0);
        applyStimulus("jrFar",    9'b000_000_011,  1'b0, 8'h20, 0, 1'b0);
        applyStimulus("aluNoise", 9'b011_000_000,  1'b0, 8'h00, 0, 1'b1);
        applyStimulus("beqWrap",  9'b110_000_000,  1'b1, 8'hDF, 0, 1'b0);
        applyStimulus("nopWrap",  9'b111_000_000,  1'b0, 8'h00, 0, 1'b0);
        applyStimulus("add2",     9'b010_01_10_00, 1'b0, 8'h00, 0, 1'b0);
        applyStimulus("halt",     9'b111_000_011,  1'b0, 8'h00, 0, 1'b0);

        checkOutput("halt.busy", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("halt.pcFrozen", 32'(bus.pc),     32'(modelPc));
        checkOutput("halt.stays",    32'(bus.halted), 32'd1);

        pulseStart();
        checkOutput("haltStart.pcCleared", 32'(bus.pc),     32'd0);
        checkOutput("haltStart.halted",    32'(bus.halted), 32'd0);
        resetDuringMem();

        pulseStart();
        applyStimulus("addAfterReset", 9'b010_01_10_00, 1'b0, 8'h00, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
